// File: rtl/inverse_rotate_scan.sv
// Raster scanner that maps each destination pixel through an inverse rotation
// about the frame centre, producing fixed-point source coordinates.
module inverse_rotate_scan #(
  parameter int IN_WIDTH    = 12,
  parameter int ANGLE_WIDTH = 10,
  parameter int FRAC_WIDTH  = 4
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic                                  start,
  input  logic signed [ANGLE_WIDTH-1:0]         cos_theta,
  input  logic signed [ANGLE_WIDTH-1:0]         sin_theta,
  input  logic        [IN_WIDTH-2:0]            num_cols,
  input  logic        [IN_WIDTH-2:0]            num_rows,
  output logic                                  busy,
  output logic                                  done,
  output logic                                  out_valid,
  input  logic                                  out_ready,
  output logic        [IN_WIDTH-2:0]            xd,
  output logic        [IN_WIDTH-2:0]            yd,
  output logic signed [IN_WIDTH+FRAC_WIDTH:0]   xs,
  output logic signed [IN_WIDTH+FRAC_WIDTH:0]   ys,
  output logic                                  in_bounds,
  output logic                                  first,
  output logic                                  last
);
  localparam int CW    = IN_WIDTH - 1;
  localparam int PW    = IN_WIDTH + ANGLE_WIDTH + 1;
  localparam int SW    = IN_WIDTH + FRAC_WIDTH + 1;
  localparam int SHIFT = ANGLE_WIDTH - 2 - FRAC_WIDTH;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t state_q, state_d;
  logic busy_q, busy_d, done_q, done_d;
  logic signed [ANGLE_WIDTH-1:0] cos_q, cos_d, sin_q, sin_d;
  logic [CW-1:0] cols_q, cols_d, rows_q, rows_d;
  logic [CW-1:0] cnt_x_q, cnt_x_d, cnt_y_q, cnt_y_d;

  logic s1_valid_q, s1_valid_d, s1_first_q, s1_first_d, s1_last_q, s1_last_d;
  logic [CW-1:0] s1_xd_q, s1_xd_d, s1_yd_q, s1_yd_d;

  logic s2_valid_q, s2_valid_d, s2_first_q, s2_first_d, s2_last_q, s2_last_d;
  logic [CW-1:0] s2_xd_q, s2_xd_d, s2_yd_q, s2_yd_d;
  logic signed [PW-1:0] s2_xa_q, s2_xa_d, s2_xb_q, s2_xb_d;
  logic signed [PW-1:0] s2_ya_q, s2_ya_d, s2_yb_q, s2_yb_d;

  logic s3_valid_q, s3_valid_d, s3_first_q, s3_first_d, s3_last_q, s3_last_d;
  logic s3_inb_q, s3_inb_d;
  logic [CW-1:0] s3_xd_q, s3_xd_d, s3_yd_q, s3_yd_d;
  logic signed [SW-1:0] s3_xs_q, s3_xs_d, s3_ys_q, s3_ys_d;

  logic advance, at_end;
  logic [CW-1:0] cx, cy;
  logic signed [IN_WIDTH-1:0] xc, yc;
  logic signed [PW-1:0] xc_w, yc_w, cos_w, sin_w;
  logic signed [PW-1:0] sum_x, sum_y, sh_x, sh_y, x_full, y_full, x_int, y_int;
  logic signed [PW-1:0] cols_w, rows_w;
  logic [PW-1:0] cx_f, cy_f;

  always_comb begin
    // One global stall: every stage moves only when the output slot frees up.
    advance = !s3_valid_q || out_ready;
    at_end  = (cnt_x_q == cols_q - 1'b1) && (cnt_y_q == rows_q - 1'b1);
    cx      = cols_q >> 1;
    cy      = rows_q >> 1;

    xc    = $signed({1'b0, s1_xd_q}) - $signed({1'b0, cx});
    yc    = $signed({1'b0, s1_yd_q}) - $signed({1'b0, cy});
    xc_w  = PW'(xc);
    yc_w  = PW'(yc);
    cos_w = PW'(cos_q);
    sin_w = PW'(sin_q);

    // Shift and recentre are kept as separate signed steps so >>> stays arithmetic.
    sum_x  = s2_xa_q + s2_xb_q;
    sum_y  = s2_ya_q + s2_yb_q;
    sh_x   = sum_x >>> SHIFT;
    sh_y   = sum_y >>> SHIFT;
    cx_f   = PW'(cx) << FRAC_WIDTH;
    cy_f   = PW'(cy) << FRAC_WIDTH;
    x_full = sh_x + $signed(cx_f);
    y_full = sh_y + $signed(cy_f);
    x_int  = x_full >>> FRAC_WIDTH;
    y_int  = y_full >>> FRAC_WIDTH;
    cols_w = $signed(PW'(cols_q));
    rows_w = $signed(PW'(rows_q));

    state_d = state_q;  busy_d = busy_q;  done_d = 1'b0;
    cos_d = cos_q;  sin_d = sin_q;  cols_d = cols_q;  rows_d = rows_q;
    cnt_x_d = cnt_x_q;  cnt_y_d = cnt_y_q;
    s1_valid_d = s1_valid_q; s1_first_d = s1_first_q; s1_last_d = s1_last_q;
    s1_xd_d = s1_xd_q; s1_yd_d = s1_yd_q;
    s2_valid_d = s2_valid_q; s2_first_d = s2_first_q; s2_last_d = s2_last_q;
    s2_xd_d = s2_xd_q; s2_yd_d = s2_yd_q;
    s2_xa_d = s2_xa_q; s2_xb_d = s2_xb_q; s2_ya_d = s2_ya_q; s2_yb_d = s2_yb_q;
    s3_valid_d = s3_valid_q; s3_first_d = s3_first_q; s3_last_d = s3_last_q;
    s3_inb_d = s3_inb_q; s3_xd_d = s3_xd_q; s3_yd_d = s3_yd_q;
    s3_xs_d = s3_xs_q; s3_ys_d = s3_ys_q;

    case (state_q)
      IDLE: if (start) begin
        cos_d = cos_theta;  sin_d = sin_theta;
        cols_d = num_cols;  rows_d = num_rows;
        cnt_x_d = '0;  cnt_y_d = '0;
        if (num_cols == '0 || num_rows == '0) begin
          done_d = 1'b1;
        end else begin
          state_d = RUN;
          busy_d  = 1'b1;
        end
      end
      RUN: if (advance) begin
        if (at_end) begin
          state_d = DRAIN;
        end else if (cnt_x_q == cols_q - 1'b1) begin
          cnt_x_d = '0;
          cnt_y_d = cnt_y_q + 1'b1;
        end else begin
          cnt_x_d = cnt_x_q + 1'b1;
        end
      end
      DRAIN: if (s3_valid_q && out_ready && s3_last_q) begin
        state_d = IDLE;
        busy_d  = 1'b0;
        done_d  = 1'b1;
      end
      default: state_d = IDLE;
    endcase

    if (advance) begin
      s1_valid_d = (state_q == RUN);
      s1_xd_d    = cnt_x_q;
      s1_yd_d    = cnt_y_q;
      s1_first_d = (cnt_x_q == '0) && (cnt_y_q == '0);
      s1_last_d  = at_end;

      s2_valid_d = s1_valid_q; s2_first_d = s1_first_q; s2_last_d = s1_last_q;
      s2_xd_d    = s1_xd_q;    s2_yd_d    = s1_yd_q;
      s2_xa_d    = xc_w * cos_w;
      s2_xb_d    = yc_w * sin_w;
      s2_ya_d    = -(xc_w * sin_w);
      s2_yb_d    = yc_w * cos_w;

      s3_valid_d = s2_valid_q; s3_first_d = s2_first_q; s3_last_d = s2_last_q;
      s3_xd_d    = s2_xd_q;    s3_yd_d    = s2_yd_q;
      s3_xs_d    = x_full[SW-1:0];
      s3_ys_d    = y_full[SW-1:0];
      s3_inb_d   = !x_int[PW-1] && (x_int < cols_w) && !y_int[PW-1] && (y_int < rows_w);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;  busy_q <= 1'b0;  done_q <= 1'b0;
      cos_q <= '0;  sin_q <= '0;  cols_q <= '0;  rows_q <= '0;
      cnt_x_q <= '0;  cnt_y_q <= '0;
      s1_valid_q <= 1'b0; s1_first_q <= 1'b0; s1_last_q <= 1'b0;
      s1_xd_q <= '0; s1_yd_q <= '0;
      s2_valid_q <= 1'b0; s2_first_q <= 1'b0; s2_last_q <= 1'b0;
      s2_xd_q <= '0; s2_yd_q <= '0;
      s2_xa_q <= '0; s2_xb_q <= '0; s2_ya_q <= '0; s2_yb_q <= '0;
      s3_valid_q <= 1'b0; s3_first_q <= 1'b0; s3_last_q <= 1'b0; s3_inb_q <= 1'b0;
      s3_xd_q <= '0; s3_yd_q <= '0; s3_xs_q <= '0; s3_ys_q <= '0;
    end else begin
      state_q <= state_d;  busy_q <= busy_d;  done_q <= done_d;
      cos_q <= cos_d;  sin_q <= sin_d;  cols_q <= cols_d;  rows_q <= rows_d;
      cnt_x_q <= cnt_x_d;  cnt_y_q <= cnt_y_d;
      s1_valid_q <= s1_valid_d; s1_first_q <= s1_first_d; s1_last_q <= s1_last_d;
      s1_xd_q <= s1_xd_d; s1_yd_q <= s1_yd_d;
      s2_valid_q <= s2_valid_d; s2_first_q <= s2_first_d; s2_last_q <= s2_last_d;
      s2_xd_q <= s2_xd_d; s2_yd_q <= s2_yd_d;
      s2_xa_q <= s2_xa_d; s2_xb_q <= s2_xb_d; s2_ya_q <= s2_ya_d; s2_yb_q <= s2_yb_d;
      s3_valid_q <= s3_valid_d; s3_first_q <= s3_first_d; s3_last_q <= s3_last_d;
      s3_inb_q <= s3_inb_d;
      s3_xd_q <= s3_xd_d; s3_yd_q <= s3_yd_d; s3_xs_q <= s3_xs_d; s3_ys_q <= s3_ys_d;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign out_valid = s3_valid_q;
  assign xd        = s3_xd_q;
  assign yd        = s3_yd_q;
  assign xs        = s3_xs_q;
  assign ys        = s3_ys_q;
  assign in_bounds = s3_inb_q;
  assign first     = s3_first_q;
  assign last      = s3_last_q;
endmodule

// File: tb/tb_inverse_rotate_scan.sv
// Scoreboard bench for inverse_rotate_scan: stimulus pushes expected beats,
// a negedge monitor pops and compares them, plus done/latency/reset timing.
module tb_inverse_rotate_scan;
  logic clk = 1'b0;
  logic reset, start, out_ready;
  logic signed [9:0] cos_theta, sin_theta;
  logic [10:0] num_cols, num_rows;
  logic busy, done, out_valid, in_bounds, first, last;
  logic [10:0] xd, yd;
  logic signed [16:0] xs, ys;

  inverse_rotate_scan dut (
    .clk(clk), .reset(reset), .start(start),
    .cos_theta(cos_theta), .sin_theta(sin_theta),
    .num_cols(num_cols), .num_rows(num_rows),
    .busy(busy), .done(done), .out_valid(out_valid), .out_ready(out_ready),
    .xd(xd), .yd(yd), .xs(xs), .ys(ys),
    .in_bounds(in_bounds), .first(first), .last(last)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [10:0] xd, yd;
    logic signed [16:0] xs, ys;
    logic inb, first, last;
  } beat_t;

  beat_t exp_q[$];
  beat_t got;
  int cyc = 0;
  logic rst_at_edge = 1'b0;
  int checks = 0, failures = 0, nbeats = 0;
  int exp_done_cyc = -1, exp_valid_cyc = -1;
  int timeout_req = 0, timeout_seen = 0;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    rst_at_edge <= reset;
  end

  // Monitor: the only process that counts comparisons.
  always @(negedge clk) begin
    got.xd = xd; got.yd = yd; got.xs = xs; got.ys = ys;
    got.inb = in_bounds; got.first = first; got.last = last;
    if (timeout_req != timeout_seen) begin
      checks++; failures++;
      $display("FAIL wait_timeout got timeouts=%0d required 0", timeout_req);
      timeout_seen = timeout_req;
    end
    if (rst_at_edge) begin
      checks++;
      if (out_valid || busy || done || xd != 0 || yd != 0 || xs != 0 || ys != 0 ||
          in_bounds || first || last) begin
        failures++;
        $display("FAIL reset_state got v=%0b busy=%0b done=%0b xd=%0d yd=%0d xs=%0d ys=%0d ib=%0b f=%0b l=%0b required all 0",
                 out_valid, busy, done, xd, yd, xs, ys, in_bounds, first, last);
      end
      exp_q.delete();
      exp_done_cyc = -1;
      exp_valid_cyc = -1;
    end else begin
      if (done || cyc == exp_done_cyc) begin
        checks++;
        if (!(done && cyc == exp_done_cyc && !busy)) begin
          failures++;
          $display("FAIL done_timing got done=%0b busy=%0b at cyc=%0d required done=1 busy=0 at cyc=%0d",
                   done, busy, cyc, exp_done_cyc);
        end
      end
      if (cyc == exp_valid_cyc) begin
        checks++;
        if (!out_valid) begin
          failures++;
          $display("FAIL first_latency got out_valid=0 at cyc=%0d required 1", cyc);
        end
      end
      if (out_valid) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL beat_unexpected got xd=%0d yd=%0d required no beat", xd, yd);
        end else begin
          if (got != exp_q[0]) begin
            failures++;
            $display("FAIL beat got xd=%0d yd=%0d xs=%0d ys=%0d ib=%0b f=%0b l=%0b required xd=%0d yd=%0d xs=%0d ys=%0d ib=%0b f=%0b l=%0b",
                     got.xd, got.yd, got.xs, got.ys, got.inb, got.first, got.last,
                     exp_q[0].xd, exp_q[0].yd, exp_q[0].xs, exp_q[0].ys,
                     exp_q[0].inb, exp_q[0].first, exp_q[0].last);
          end
          if (out_ready) begin
            if (exp_q[0].last) exp_done_cyc = cyc + 1;
            void'(exp_q.pop_front());
          end
        end
        if (out_ready) nbeats++;
      end
      if (start && !busy && !reset) begin
        if (num_cols == 0 || num_rows == 0) exp_done_cyc = cyc + 1;
        else exp_valid_cyc = cyc + 4;
      end
    end
  end

  // mode 0: identity; mode 1: 90 degrees on a 4x4 frame (centre 2,2).
  task automatic push_frame(input int mode, input int c, input int r);
    beat_t b;
    for (int y = 0; y < r; y++) begin
      for (int x = 0; x < c; x++) begin
        b.xd = 11'(x);
        b.yd = 11'(y);
        if (mode == 0) begin
          b.xs = 17'(x * 16);
          b.ys = 17'(y * 16);
          b.inb = 1'b1;
        end else begin
          b.xs = 17'(y * 16);
          b.ys = 17'(64 - 16 * x);
          b.inb = (x != 0);
        end
        b.first = (x == 0 && y == 0);
        b.last = (x == c - 1 && y == r - 1);
        exp_q.push_back(b);
      end
    end
  endtask

  task automatic do_start(input logic signed [9:0] c, input logic signed [9:0] s,
                          input logic [10:0] nc, input logic [10:0] nr);
    @(posedge clk); #1;
    cos_theta = c; sin_theta = s; num_cols = nc; num_rows = nr; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_idle();
    int k;
    k = 0;
    repeat (3) @(posedge clk);
    while ((busy || out_valid || exp_q.size() != 0) && k < 300) begin
      @(posedge clk);
      k++;
    end
    if (k >= 300) timeout_req++;
    repeat (2) @(posedge clk);
  endtask

  task automatic wait_beats(input int n);
    int k;
    k = 0;
    while (nbeats < n && k < 300) begin
      @(posedge clk);
      k++;
    end
    if (k >= 300) timeout_req++;
  endtask

  int base;

  initial begin
    reset = 1'b1; start = 1'b0; out_ready = 1'b1;
    cos_theta = '0; sin_theta = '0; num_cols = '0; num_rows = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    repeat (2) @(posedge clk);

    push_frame(0, 4, 3);
    do_start(10'sd256, 10'sd0, 11'd4, 11'd3);
    wait_idle();

    push_frame(1, 4, 4);
    do_start(10'sd0, 10'sd256, 11'd4, 11'd4);
    wait_idle();

    base = nbeats;
    push_frame(0, 4, 3);
    do_start(10'sd256, 10'sd0, 11'd4, 11'd3);
    wait_beats(base + 5);
    #1 out_ready = 1'b0;
    repeat (5) @(posedge clk);
    #1 out_ready = 1'b1;
    wait_idle();

    do_start(10'sd256, 10'sd0, 11'd0, 11'd3);
    wait_idle();
    do_start(10'sd256, 10'sd0, 11'd5, 11'd0);
    wait_idle();

    base = nbeats;
    push_frame(0, 4, 3);
    do_start(10'sd256, 10'sd0, 11'd4, 11'd3);
    wait_beats(base + 6);
    #1 reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    repeat (3) @(posedge clk);
    push_frame(0, 4, 3);
    do_start(10'sd256, 10'sd0, 11'd4, 11'd3);
    wait_idle();

    base = nbeats;
    push_frame(0, 4, 3);
    do_start(10'sd256, 10'sd0, 11'd4, 11'd3);
    wait_beats(base + 3);
    #1 sin_theta = 10'sd100; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    wait_idle();

    repeat (2) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/inverse_rotate_scan.md
INVERSE_ROTATE_SCAN -- requirements
Module: inverse_rotate_scan

Interface
REQ-001 SHALL have parameter IN_WIDTH, default 12: signed destination/source integer coordinate width; frame dimensions are IN_WIDTH-1 bits.
REQ-002 SHALL have parameter ANGLE_WIDTH, default 10: signed cos/sin width, where 1.0 = 2^(ANGLE_WIDTH-2).
REQ-003 SHALL have parameter FRAC_WIDTH, default 4: number of fractional bits on source coordinates; FRAC_WIDTH <= ANGLE_WIDTH-2.
REQ-004 SHALL have port clk, input, 1 bit: the only clock; all logic is rising-edge.
REQ-005 SHALL have port reset, input, 1 bit: synchronous, active-high.
REQ-006 SHALL have port start, input, 1 bit: a one-cycle request to begin a frame scan.
REQ-007 SHALL have ports cos_theta and sin_theta, input, ANGLE_WIDTH bits, signed: the rotation angle; latched on an accepted start.
REQ-008 SHALL have ports num_cols and num_rows, input, IN_WIDTH-1 bits: the frame size; latched on an accepted start.
REQ-009 SHALL have port busy, output, 1 bit: high from an accepted start until done.
REQ-010 SHALL have port done, output, 1 bit: a one-cycle pulse at the end of a frame.
REQ-011 SHALL have port out_valid, output, 1 bit, and port out_ready, input, 1 bit: the output beat handshake.
REQ-012 SHALL have ports xd and yd, output, IN_WIDTH-1 bits: the destination raster position of the beat.
REQ-013 SHALL have ports xs and ys, output, IN_WIDTH+FRAC_WIDTH+1 bits, signed: the source coordinate of the beat, with FRAC_WIDTH fractional bits.
REQ-014 SHALL have port in_bounds, output, 1 bit: the source integer position lies inside the frame.
REQ-015 SHALL have ports first and last, output, 1 bit each: the beat is (0,0) or (num_cols-1,num_rows-1).

Function
REQ-016 SHALL use FSM states IDLE, RUN and DRAIN.
REQ-017 SHALL accept start only in IDLE; start in RUN or DRAIN is ignored and does not reload the latched parameters.
REQ-018 SHALL, on an accepted start with num_cols==0 or num_rows==0, pulse done on the next cycle, emit no beats and return to IDLE.
REQ-019 SHALL, in RUN, have the raster counter issue destination coordinates xd-fastest: xd 0..num_cols-1, then yd increments.
REQ-020 SHALL leave RUN for DRAIN after the last coordinate is issued.
REQ-021 SHALL compute, with cx=num_cols>>1 and cy=num_rows>>1: xc=xd-cx and yc=yd-cy, both signed IN_WIDTH bits.
REQ-022 SHALL compute the products xc*cos+yc*sin for x and -xc*sin+yc*cos for y at full width IN_WIDTH+ANGLE_WIDTH+1.
REQ-023 SHALL arithmetic-right-shift each sum by ANGLE_WIDTH-2-FRAC_WIDTH (floor), then add cx<<FRAC_WIDTH to x and cy<<FRAC_WIDTH to y; no saturation is needed because the width is sufficient.
REQ-024 SHALL set in_bounds = (xs>>>FRAC_WIDTH) in [0,num_cols-1] AND (ys>>>FRAC_WIDTH) in [0,num_rows-1], evaluated on the full-width value.
REQ-025 SHALL be a 3-stage pipeline (counter, centre+multiply, sum+recentre+bounds); the first beat's out_valid rises 3 cycles after start is accepted.
REQ-026 SHALL, with out_ready held high, sustain 1 beat/cycle.
REQ-027 SHALL transfer a beat on a cycle with out_valid && out_ready.
REQ-028 SHALL, when out_valid && !out_ready, stall all stages; xd, yd, xs, ys, in_bounds, first and last are held stable and no beat is dropped or duplicated.
REQ-029 SHALL not make out_valid depend combinationally on out_ready.
REQ-030 SHALL pulse done one cycle after the beat with last transfers, deassert busy on the same cycle, and return to IDLE.
REQ-031 SHALL emit exactly num_cols*num_rows beats per frame.
REQ-032 SHALL allow a start on the cycle after done.

Reset
REQ-033 SHALL, on reset, regardless of state, enter IDLE and drive busy=0, done=0 and out_valid=0; pipeline contents are discarded.
REQ-034 SHALL, on reset, drive xd, yd, xs, ys, in_bounds, first and last to 0.
REQ-035 SHALL, after a mid-frame reset, not emit beats from the aborted frame.

Verification
REQ-036 SHALL cover identity: cos=256, sin=0, 4x3 frame -> 12 beats, xs=xd*16, ys=yd*16, all in_bounds=1; first on (0,0), last on (3,2); done 1 cycle after last.
REQ-037 SHALL cover 90 degrees: cos=0, sin=256, 4x4 frame -> beat (0,0) gives xs=0, ys=64, in_bounds=0; beat (1,0) gives xs=0, ys=48, in_bounds=1.
REQ-038 SHALL cover backpressure: identity 4x3 with out_ready low for 5 cycles at beat 5 -> outputs frozen on beat 5, 12 beats total, in order.
REQ-039 SHALL cover zero size: num_cols=0 -> no out_valid, done exactly 1 cycle after start.
REQ-040 SHALL cover mid-frame reset: reset at beat 6 -> next cycle out_valid=0, busy=0; a new start yields a clean full frame beginning at (0,0).
REQ-041 SHALL cover start while busy: pulse start with different sin at beat 3 -> ignored; the frame completes with the original values.
